// File: rtl/aes_pkg.sv
// ShiftRows definitions shared by the AES datapath: mode encodings, Rijndael
// row offsets and the column-major byte packing of the state vector.
package aes_pkg;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned COL_W  = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [MODE_W-1:0] MODE_FWD = 2'b00;
  localparam logic [MODE_W-1:0] MODE_INV = 2'b01;
  localparam logic [MODE_W-1:0] MODE_BYP = 2'b10;

  // Rijndael cyclic shift for a row; 256-bit blocks shift rows 2 and 3 one further
  function automatic int unsigned row_offset(input int unsigned nb, input int unsigned row);
    if (nb == 8 && row >= 2) return row + 1;
    return row;
  endfunction

  // LSB position of byte (row, col); column 0 sits in the most significant word
  function automatic int unsigned byte_lsb(input int unsigned nb, input int unsigned col,
                                           input int unsigned row);
    return COL_W * nb - BYTE_W - COL_W * col - BYTE_W * row;
  endfunction

  // Source column feeding output (row, col); bypass and the reserved code map to identity
  function automatic int unsigned src_col(input int unsigned nb, input int unsigned col,
                                          input int unsigned row, input logic [MODE_W-1:0] mode);
    int unsigned off;
    off = row_offset(nb, row);
    case (mode)
      MODE_FWD: return (col + off) % nb;
      MODE_INV: return (col + nb - off) % nb;
      default:  return col;
    endcase
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows / bypass byte permutation for an
// NB-column Rijndael state; pure wiring, no arithmetic on the data.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int unsigned NB = 4
) (
  input  logic [COL_W*NB-1:0] state,
  input  logic [MODE_W-1:0]   mode,
  output logic [COL_W*NB-1:0] perm_state
);

  localparam int unsigned STATE_W = COL_W * NB;
  localparam int unsigned IDX_W   = $clog2(STATE_W);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_perm: NB must be 4, 6 or 8");
  end

  always_comb begin
    perm_state = '0;
    for (int unsigned c = 0; c < NB; c++) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        perm_state[IDX_W'(byte_lsb(NB, c, r)) +: BYTE_W] =
          state[IDX_W'(byte_lsb(NB, src_col(NB, c, r, mode), r)) +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Elastic pipelined ShiftRows stage: input register S1, optional output
// register S2, valid/ready on both sides with the mode travelling with its data.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int unsigned NB      = 4,
  parameter int unsigned OUT_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MODE_W-1:0]   in_mode,
  input  logic [COL_W*NB-1:0] in_state,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MODE_W-1:0]   out_mode,
  output logic [COL_W*NB-1:0] out_state
);

  localparam int unsigned STATE_W = COL_W * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (OUT_REG > 1) begin : g_bad_out_reg
    $error("shift_rows_pipe: OUT_REG must be 0 or 1");
  end

  logic               s1_valid;
  logic [STATE_W-1:0] s1_state;
  logic [MODE_W-1:0]  s1_mode;
  logic [STATE_W-1:0] s1_perm;
  logic               next_accept;
  logic               s1_advance;
  logic               s1_capture;

  shift_rows_perm #(.NB(NB)) u_perm (
    .state      (s1_state),
    .mode       (s1_mode),
    .perm_state (s1_perm)
  );

  // Ready is derived from stage occupancy only, never from in_valid
  assign s1_advance = s1_valid && next_accept;
  assign in_ready   = !s1_valid || s1_advance;
  assign s1_capture = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_state <= '0;
      s1_mode  <= '0;
    end else if (s1_capture) begin
      s1_valid <= 1'b1;
      s1_state <= in_state;
      s1_mode  <= in_mode;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic               s2_valid;
    logic [STATE_W-1:0] s2_state;
    logic [MODE_W-1:0]  s2_mode;

    assign next_accept = !s2_valid || out_ready;

    // S2 data only moves on a load, so it holds stable under backpressure
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_state <= '0;
        s2_mode  <= '0;
      end else if (s1_advance) begin
        s2_valid <= 1'b1;
        s2_state <= s1_perm;
        s2_mode  <= s1_mode;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end

    assign out_valid = s2_valid;
    assign out_state = s2_state;
    assign out_mode  = s2_mode;
  end else begin : g_out_comb
    assign next_accept = out_ready;
    assign out_valid   = s1_valid;
    assign out_state   = s1_perm;
    assign out_mode    = s1_mode;
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: NB=4 registered, NB=4 combinational-output and
// NB=8 registered builds share one stimulus stream, checked against a byte-level model.
module tb_shift_rows_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [1:0]   in_mode;
  logic         out_ready;
  logic [127:0] in_state4;
  logic [255:0] in_state8;

  logic         rdy_a, ov_a, rdy_c, ov_c, rdy_8, ov_8;
  logic [1:0]   om_a, om_c, om_8;
  logic [127:0] os_a, os_c;
  logic [255:0] os_8;

  int nvec = 0;
  int nerr = 0;

  logic [257:0] exp_a[$], obs_a[$], exp_c[$], obs_c[$], exp_8[$], obs_8[$];

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4), .OUT_REG(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_mode(in_mode),
    .in_state(in_state4), .out_valid(ov_a), .out_ready(out_ready), .out_mode(om_a),
    .out_state(os_a));

  shift_rows_pipe #(.NB(4), .OUT_REG(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .in_mode(in_mode),
    .in_state(in_state4), .out_valid(ov_c), .out_ready(out_ready), .out_mode(om_c),
    .out_state(os_c));

  shift_rows_pipe #(.NB(8), .OUT_REG(1)) dut_8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_8), .in_mode(in_mode),
    .in_state(in_state8), .out_valid(ov_8), .out_ready(out_ready), .out_mode(om_8),
    .out_state(os_8));

  // Reference: unpack into a 4 x NB byte matrix, rotate each row, repack
  function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] st,
                                             input logic [1:0] mode);
    logic [7:0]   b [4][8];
    logic [255:0] o;
    int           off, sc;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        b[r][c] = st[32*nb-1-32*c-8*r -: 8];
    o = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        off = (nb == 8 && r >= 2) ? r + 1 : r;
        if (mode == 2'b00)      sc = (c + off) % nb;
        else if (mode == 2'b01) sc = (c - off + nb) % nb;
        else                    sc = c;
        o[32*nb-1-32*c-8*r -: 8] = b[r][sc];
      end
    return o;
  endfunction

  // Record every handshake on both sides, mid-cycle when inputs are stable
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && rdy_a) exp_a.push_back({in_mode, ref_shift(4, 256'(in_state4), in_mode)});
      if (in_valid && rdy_c) exp_c.push_back({in_mode, ref_shift(4, 256'(in_state4), in_mode)});
      if (in_valid && rdy_8) exp_8.push_back({in_mode, ref_shift(8, in_state8, in_mode)});
      if (ov_a && out_ready) obs_a.push_back({om_a, 256'(os_a)});
      if (ov_c && out_ready) obs_c.push_back({om_c, 256'(os_c)});
      if (ov_8 && out_ready) obs_8.push_back({om_8, os_8});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    exp_a.delete(); obs_a.delete(); exp_c.delete(); obs_c.delete();
    exp_8.delete(); obs_8.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; out_ready = 1'b1;
    in_state4 = '0; in_state8 = '0;
    #13;
    nvec++; if (ov_a !== 1'b0) begin nerr++; $display("FAIL reset_ov_a: got %b want 0", ov_a); end
    nvec++; if (os_a !== 128'h0) begin nerr++; $display("FAIL reset_os_a: got %h want 0", os_a); end
    nvec++; if (om_a !== 2'b00) begin nerr++; $display("FAIL reset_om_a: got %b want 00", om_a); end
    nvec++; if (rdy_a !== 1'b1) begin nerr++; $display("FAIL reset_rdy_a: got %b want 1", rdy_a); end
    nvec++; if (ov_c !== 1'b0 || os_c !== 128'h0) begin nerr++; $display("FAIL reset_c: got v=%b d=%h want 0", ov_c, os_c); end
    nvec++; if (ov_8 !== 1'b0 || os_8 !== 256'h0) begin nerr++; $display("FAIL reset_8: got v=%b d=%h want 0", ov_8, os_8); end
    #4 rst = 1'b0;
    tick();
  endtask

  task automatic test_forward_latency();
    logic [127:0] want;
    want = 128'h00050a0f_04090e03_080d0207_0c01060b;
    in_valid = 1'b1; in_mode = 2'b00; in_state4 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    tick();
    in_valid = 1'b0;
    #1;
    nvec++; if (ov_a !== 1'b0) begin nerr++; $display("FAIL fwd_lat1_ov_a: got %b want 0", ov_a); end
    nvec++; if (ov_c !== 1'b1 || os_c !== want || om_c !== 2'b00) begin nerr++; $display("FAIL fwd_comb_out: got v=%b m=%b d=%h want 1 00 %h", ov_c, om_c, os_c, want); end
    tick();
    nvec++; if (ov_a !== 1'b1 || os_a !== want || om_a !== 2'b00) begin nerr++; $display("FAIL fwd_reg_out: got v=%b m=%b d=%h want 1 00 %h", ov_a, om_a, os_a, want); end
    nvec++; if (ov_c !== 1'b0) begin nerr++; $display("FAIL fwd_comb_drain: got %b want 0", ov_c); end
    tick();
  endtask

  task automatic test_fips_roundtrip();
    logic [127:0] orig, fwd;
    orig = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    fwd  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    in_valid = 1'b1; in_mode = 2'b00; in_state4 = orig;
    tick();
    in_mode = 2'b01; in_state4 = fwd;
    #1;
    nvec++; if (os_c !== fwd) begin nerr++; $display("FAIL fips_fwd_comb: got %h want %h", os_c, fwd); end
    tick();
    in_valid = 1'b0;
    #1;
    nvec++; if (ov_a !== 1'b1 || os_a !== fwd || om_a !== 2'b00) begin nerr++; $display("FAIL fips_fwd_reg: got v=%b m=%b d=%h want 1 00 %h", ov_a, om_a, os_a, fwd); end
    nvec++; if (os_c !== orig || om_c !== 2'b01) begin nerr++; $display("FAIL fips_inv_comb: got m=%b d=%h want 01 %h", om_c, os_c, orig); end
    tick();
    nvec++; if (ov_a !== 1'b1 || os_a !== orig || om_a !== 2'b01) begin nerr++; $display("FAIL fips_inv_reg: got v=%b m=%b d=%h want 1 01 %h", ov_a, om_a, os_a, orig); end
    tick();
  endtask

  task automatic test_nb8();
    logic [255:0] seq;
    for (int i = 0; i < 32; i++) seq[255-8*i -: 8] = 8'(i);
    in_valid = 1'b1; in_mode = 2'b00; in_state8 = seq;
    tick();
    in_mode = 2'b10;
    tick();
    in_valid = 1'b0;
    #1;
    nvec++; if (os_8[255:224] !== 32'h00050e13) begin nerr++; $display("FAIL nb8_col0: got %h want 00050e13", os_8[255:224]); end
    nvec++; if (os_8[31:0] !== 32'h1c010a0f) begin nerr++; $display("FAIL nb8_col7: got %h want 1c010a0f", os_8[31:0]); end
    nvec++; if (os_8 !== ref_shift(8, seq, 2'b00)) begin nerr++; $display("FAIL nb8_fwd_full: got %h want %h", os_8, ref_shift(8, seq, 2'b00)); end
    tick();
    nvec++; if (ov_8 !== 1'b1 || os_8 !== seq || om_8 !== 2'b10) begin nerr++; $display("FAIL nb8_bypass: got v=%b m=%b d=%h want 1 10 %h", ov_8, om_8, os_8, seq); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [127:0] data [8];
    logic [1:0]   modes [8];
    logic [129:0] held;
    int           sent;
    for (int i = 0; i < 8; i++) begin
      data[i]  = {$urandom, $urandom, $urandom, $urandom};
      modes[i] = 2'($urandom_range(0, 3));
    end
    clear_queues();
    sent = 0;
    held = '0;
    for (int k = 0; k < 22; k++) begin
      out_ready = !(k >= 3 && k <= 7);
      in_valid  = (sent < 8);
      in_state4 = data[sent % 8];
      in_mode   = modes[sent % 8];
      in_state8 = {data[sent % 8], ~data[sent % 8]};
      #1;
      if (k == 3) held = {om_a, os_a};
      if (k == 5) begin
        nvec++; if (rdy_a !== 1'b0) begin nerr++; $display("FAIL bp_in_ready_low: got %b want 0", rdy_a); end
      end
      if (k == 7) begin
        nvec++; if (ov_a !== 1'b1 || {om_a, os_a} !== held) begin nerr++; $display("FAIL bp_hold: got v=%b %h want 1 %h", ov_a, {om_a, os_a}, held); end
      end
      if (k >= 8 && k <= 12) begin
        nvec++; if (rdy_a !== 1'b1) begin nerr++; $display("FAIL bp_full_rate k=%0d: got %b want 1", k, rdy_a); end
      end
      if (in_valid && rdy_a) sent++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    nvec++; if (obs_a.size() != 8 || exp_a.size() != 8) begin nerr++; $display("FAIL bp_count: got %0d out %0d in want 8 8", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < 8 && i < obs_a.size() && i < exp_a.size(); i++) begin
      nvec++; if (obs_a[i] !== exp_a[i]) begin nerr++; $display("FAIL bp_order[%0d]: got %h want %h", i, obs_a[i], exp_a[i]); end
    end
    for (int i = 0; i < 8; i++) begin
      nvec++; if (exp_a.size() > i && exp_a[i][257:256] !== modes[i]) begin nerr++; $display("FAIL bp_mode[%0d]: got %b want %b", i, exp_a[i][257:256], modes[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [127:0] d;
    in_valid = 1'b1; out_ready = 1'b1; in_mode = 2'b00;
    in_state4 = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_state4 = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_valid = 1'b0;
    #1;
    nvec++; if (ov_a !== 1'b1) begin nerr++; $display("FAIL rst_mid_inflight: got %b want 1", ov_a); end
    #1 rst = 1'b1;
    #1;
    nvec++; if (ov_a !== 1'b0 || os_a !== 128'h0 || om_a !== 2'b00) begin nerr++; $display("FAIL rst_mid_a: got v=%b m=%b d=%h want 0", ov_a, om_a, os_a); end
    nvec++; if (ov_c !== 1'b0 || os_c !== 128'h0) begin nerr++; $display("FAIL rst_mid_c: got v=%b d=%h want 0", ov_c, os_c); end
    nvec++; if (ov_8 !== 1'b0 || os_8 !== 256'h0) begin nerr++; $display("FAIL rst_mid_8: got v=%b d=%h want 0", ov_8, os_8); end
    #3 rst = 1'b0;
    #1;
    nvec++; if (rdy_a !== 1'b1 || rdy_c !== 1'b1) begin nerr++; $display("FAIL rst_mid_ready: got %b %b want 1 1", rdy_a, rdy_c); end
    clear_queues();
    tick();
    d = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; in_mode = 2'b01; in_state4 = d;
    tick();
    in_valid = 1'b0;
    #1;
    nvec++; if (ov_a !== 1'b0 || ov_c !== 1'b1) begin nerr++; $display("FAIL rst_mid_lat1: got %b %b want 0 1", ov_a, ov_c); end
    tick();
    nvec++; if (ov_a !== 1'b1 || os_a !== 128'(ref_shift(4, 256'(d), 2'b01)) || om_a !== 2'b01) begin nerr++; $display("FAIL rst_mid_next: got v=%b m=%b d=%h want 1 01 %h", ov_a, om_a, os_a, 128'(ref_shift(4, 256'(d), 2'b01))); end
    tick();
  endtask

  task automatic test_random();
    clear_queues();
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_mode   = 2'($urandom_range(0, 3));
      in_state4 = {$urandom, $urandom, $urandom, $urandom};
      in_state8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    nvec++; if (obs_a.size() != exp_a.size()) begin nerr++; $display("FAIL rnd_count_a: got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      nvec++; if (obs_a[i] !== exp_a[i]) begin nerr++; $display("FAIL rnd_a[%0d]: got %h want %h", i, obs_a[i], exp_a[i]); end
    end
    nvec++; if (obs_c.size() != exp_c.size()) begin nerr++; $display("FAIL rnd_count_c: got %0d want %0d", obs_c.size(), exp_c.size()); end
    for (int i = 0; i < obs_c.size() && i < exp_c.size(); i++) begin
      nvec++; if (obs_c[i] !== exp_c[i]) begin nerr++; $display("FAIL rnd_c[%0d]: got %h want %h", i, obs_c[i], exp_c[i]); end
    end
    nvec++; if (obs_8.size() != exp_8.size()) begin nerr++; $display("FAIL rnd_count_8: got %0d want %0d", obs_8.size(), exp_8.size()); end
    for (int i = 0; i < obs_8.size() && i < exp_8.size(); i++) begin
      nvec++; if (obs_8[i] !== exp_8[i]) begin nerr++; $display("FAIL rnd_8[%0d]: got %h want %h", i, obs_8[i], exp_8[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_forward_latency();
    test_fips_roundtrip();
    test_nb8();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, pipelined successor to the combinational ShiftRows stage in the AES datapath.
- Supports Rijndael block widths of NB = 4, 6 or 8 columns, with a per-transfer mode: forward ShiftRows, inverse ShiftRows or bypass.
- Uses valid/ready handshakes on both sides and carries the mode alongside the data.
- Sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey in the round pipeline.

Parameters:
- NB, 4, number of 32-bit state columns; legal values are 4, 6 and 8. Any other value is a static elaboration error.
- OUT_REG, 1, 1 = registered output stage (latency 2); 0 = permutation drives outputs combinationally from the input stage (latency 1).

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, input transfer valid.
- in_ready, output, 1, block can accept an input this cycle.
- in_mode, input, 2, operation: 00 forward, 01 inverse, 10 bypass, 11 reserved (treated as bypass).
- in_state, input, 32*NB, state; column c occupies bits [32*NB-1-32c -: 32]; row r of column c is the byte at [32*NB-1-32c-8r -: 8].
- out_valid, output, 1, output transfer valid.
- out_ready, input, 1, downstream accepts the output.
- out_mode, output, 2, in_mode of the transfer currently on out_state.
- out_state, output, 32*NB, permuted state in the same packing as in_state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all valid flags 0, all data/mode registers 0, out_valid=0, out_state=0, out_mode=00, in_ready=1.
- Row offsets (Rijndael):
  - NB=4 or 6: row 0..3 → 0,1,2,3.
  - NB=8: row 0..3 → 0,1,3,4.
- Forward: out row r, column c = in row r, column (c+off[r]) mod NB.
- Inverse: out row r, column c = in row r, column (c-off[r]) mod NB.
- Bypass/reserved: out = in.
- Column indices wrap modulo NB; there is no arithmetic on data.
- Stage S1 (input register):
  - Captures in_state and in_mode when in_valid && in_ready.
  - s1_valid is set on capture and cleared when S1 advances without a new capture.
- Stage S2 (OUT_REG=1):
  - Captures permute(S1) when s1_valid && (!s2_valid || out_ready).
  - out_valid = s2_valid.
- OUT_REG=0:
  - out_state = permute(S1) combinationally; out_valid = s1_valid.
- Ready chain:
  - Every stage register is elastic: a stage accepts when empty or when its content leaves the same cycle.
  - in_ready = !s1_valid || s1_advance, where s1_advance = s1_valid && (next stage accepts).
  - in_ready must not depend combinationally on in_valid.
- Throughput: one transfer per cycle when out_ready is held high.
  - Latency with OUT_REG=1 is 2 cycles from input handshake to out_valid.
  - Latency with OUT_REG=0 is 1 cycle.
- Backpressure: while out_valid && !out_ready, out_state and out_mode hold stable.
  - Both stages fill, then in_ready drops.
  - No data is dropped or duplicated.
- Simultaneous events:
  - A full pipeline with out_ready=1 and in_valid=1 accepts the new input and shifts every stage in the same edge.
  - Mode may differ on every transfer; each mode travels with its own data.
- Reset mid-operation: all in-flight transfers are discarded immediately (asynchronous). out_valid falls without waiting for a clock edge.
- Data registers are reset, so X never appears on out_state after reset.

Decomposition:
- Package aes_pkg holds:
  - Mode localparams MODE_FWD=2'b00, MODE_INV=2'b01, MODE_BYP=2'b10.
  - A function returning the row offset for (NB, row).
  - A byte-index helper for the column-major packing.
- Sub-module shift_rows_perm: purely combinational, parameter NB, inputs state and mode, output permuted state. It is instantiated once and reused by MixColumns-side tests.
- shift_rows_pipe holds only the stage registers and handshake logic.

Test Plan:
- NB=4, OUT_REG=1, forward mode.
  - Stimulus: in_state=128'h00010203_04050607_08090a0b_0c0d0e0f.
  - Required: 2 cycles later out_state=128'h00050a0f_04090e03_080d0207_0c01060b, out_mode=00.
- NB=4, FIPS-197 Appendix B round 1.
  - Forward: 128'hd42711ae_e0bf98f1_b8b45de5_1e415230 → 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5.
  - Inverse: feeding that output with mode 01 must return the original input.
- NB=8, forward, input bytes 00..1f in order.
  - Required: out column 0 = 32'h00050e13 and column 7 = 32'h1c010a0f.
  - Bypass mode (10) returns the input unchanged.
- Backpressure: stream 8 back-to-back transfers with out_ready=0 for cycles 3..7.
  - Required: in_ready=0 once 2 entries are held.
  - Output order, data and per-transfer modes exactly match input order; no loss or duplication.
  - Full rate resumes after out_ready returns high.
- Reset mid-stream: assert rst asynchronously between edges while 2 transfers are in flight.
  - Required: out_valid=0 and out_state=0 immediately; in_ready=1 after release.
  - The next transfer emerges with the correct latency.
- OUT_REG=0 build: same vectors as the first scenario.
  - Required: out_valid 1 cycle after handshake.
  - Random stimulus against the reference model with random in_valid/out_ready shows zero mismatches.
